// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state encoding and word-level helpers.
package aes_pkg;

    localparam int unsigned AES_NK = 8;
    localparam int unsigned AES_NR = 14;
    localparam int unsigned AES_NW = 4 * (AES_NR + 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_e;

    // Round constant for schedule step idx = i/8; only 1..7 are ever used.
    function automatic logic [7:0] rcon(input logic [2:0] idx);
        logic [7:0] rc;
        case (idx)
            3'd1:    rc = 8'h01;
            3'd2:    rc = 8'h02;
            3'd3:    rc = 8'h04;
            3'd4:    rc = 8'h08;
            3'd5:    rc = 8'h10;
            3'd6:    rc = 8'h20;
            3'd7:    rc = 8'h40;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Left rotate by one byte: {b0,b1,b2,b3} -> {b1,b2,b3,b0}.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_c
);

    // Entry n lives at bits [2047-8n -: 8]; row k holds entries 16k..16k+15.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Table lookup; index reversed because entry 0 is at the MSB end.
    assign out_c = SBOX_TBL[{8'd255 - in_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes256_key_expand.sv
// AES-256 forward key expansion, one schedule word per clock, with a
// registered round-key read port and the final 256 bits for decryption.
module aes256_key_expand
    import aes_pkg::*;
#(
    parameter int unsigned NK = AES_NK,
    parameter int unsigned NR = AES_NR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [32*NK-1:0] key,
    output logic             busy,
    output logic             done,
    output logic             key_valid,
    input  logic [3:0]       rd_idx,
    output logic [127:0]     rd_key,
    output logic [255:0]     dec_key
);

    localparam int unsigned NW     = 4 * (NR + 1);
    localparam int unsigned IDX_W  = $clog2(AES_NW);
    localparam int unsigned KSEL_W = $clog2(32 * NK);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              key_valid_q, key_valid_d;
    logic [127:0]      rd_key_q, rd_key_d;
    logic [31:0]       mem_q [NW];
    logic [31:0]       mem_d [NW];

    logic [31:0]       temp_c;
    logic [31:0]       sub_in_c;
    logic [31:0]       sub_out_c;
    logic [31:0]       t_c;

    // Previous word feeds the transform; only meaningful while expanding.
    assign temp_c   = mem_q[cnt_q - IDX_W'(1)];
    assign sub_in_c = cnt_q[2] ? temp_c : rot_word(temp_c);

    // SubWord built from four byte S-boxes.
    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte (sub_in_c[8*b +: 8]),
            .out_c   (sub_out_c[8*b +: 8])
        );
    end

    // Per-position transform t applied to w[i-1].
    always_comb begin
        t_c = temp_c;
        if (cnt_q[2:0] == 3'd0) begin
            t_c = sub_out_c ^ {rcon(cnt_q[5:3]), 24'h0};
        end else if (cnt_q[2:0] == 3'd4) begin
            t_c = sub_out_c;
        end
    end

    // Next-state: key load, word generation, completion flags, read port.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        key_valid_d = key_valid_q;
        mem_d       = mem_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    for (int unsigned w = 0; w < NK; w++) begin
                        mem_d[IDX_W'(w)] = key[KSEL_W'((NK - 1 - w) * 32) +: 32];
                    end
                    cnt_d       = IDX_W'(NK);
                    busy_d      = 1'b1;
                    key_valid_d = 1'b0;
                    state_d     = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                mem_d[cnt_q] = mem_q[cnt_q - IDX_W'(8)] ^ t_c;
                if (cnt_q == IDX_W'(NW - 1)) begin
                    cnt_d       = '0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    key_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rd_idx > 4'(NR)) begin
            rd_key_d = '0;
        end else begin
            rd_key_d = {mem_q[{rd_idx, 2'b00}], mem_q[{rd_idx, 2'b01}],
                        mem_q[{rd_idx, 2'b10}], mem_q[{rd_idx, 2'b11}]};
        end
    end

    // State, storage and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            key_valid_q <= 1'b0;
            rd_key_q    <= '0;
            mem_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            key_valid_q <= key_valid_d;
            rd_key_q    <= rd_key_d;
            mem_q       <= mem_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign key_valid = key_valid_q;
    assign rd_key    = rd_key_q;
    assign dec_key   = {mem_q[NW-8], mem_q[NW-7], mem_q[NW-6], mem_q[NW-5],
                        mem_q[NW-4], mem_q[NW-3], mem_q[NW-2], mem_q[NW-1]};

endmodule

// File: tb/tb_aes256_key_expand.sv
// Directed and random checks of the AES-256 key expansion engine against
// FIPS-197 vectors and an independent GF(2^8)-based schedule model.
module tb_aes256_key_expand;

    logic         clk;
    logic         rst;
    logic         start;
    logic [255:0] key;
    logic         busy;
    logic         done;
    logic         key_valid;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
    logic [255:0] dec_key;

    int n_tests;
    int n_fail;

    logic [7:0]  sb [256];
    logic [31:0] mw [60];

    localparam logic [255:0] KEY_C3 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_B =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    aes256_key_expand dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key       (key),
        .busy      (busy),
        .done      (done),
        .key_valid (key_valid),
        .rd_idx    (rd_idx),
        .rd_key    (rd_key),
        .dec_key   (dec_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] v);
        logic [7:0] inv = 8'h00;
        logic [7:0] s;
        if (v != 8'h00) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, v);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic model_expand(input logic [255:0] k);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 8; i++) mw[i] = k[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = mw[i-1];
            if (i % 8 == 0) begin
                rc = 8'h01 << ((i / 8) - 1);
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            mw[i] = mw[i-8] ^ t;
        end
    endtask

    function automatic logic [127:0] rk(input int r);
        return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge; returns at the negedge after the accepting edge.
    task automatic start_key(input logic [255:0] k);
        @(negedge clk);
        start = 1'b1;
        key   = k;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic read_rk(input logic [3:0] idx, output logic [127:0] v);
        @(negedge clk);
        rd_idx = idx;
        @(negedge clk);
        v = rd_key;
    endtask

    // Back-to-back read of all round keys plus the out-of-range index.
    task automatic sweep(input string tag);
        @(negedge clk);
        rd_idx = 4'd0;
        for (int r = 0; r < 15; r++) begin
            @(negedge clk);
            check($sformatf("%s_rk%0d", tag, r), {128'h0, rd_key}, {128'h0, rk(r)});
            rd_idx = 4'(r + 1);
        end
        @(negedge clk);
        check($sformatf("%s_idx15", tag), {128'h0, rd_key}, 256'h0);
        check($sformatf("%s_dec", tag), dec_key, {rk(13), rk(14)});
    endtask

    initial begin
        int           cyc;
        int           done_cnt;
        int           first_done;
        logic [127:0] v;
        logic [255:0] rk_key;

        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        key     = '0;
        rd_idx  = 4'd0;
        for (int i = 0; i < 256; i++) sb[i] = sbox_ref(8'(i));

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", {255'h0, busy}, 256'h0);
        check("rst_done", {255'h0, done}, 256'h0);
        check("rst_kv", {255'h0, key_valid}, 256'h0);
        check("rst_rdkey", {128'h0, rd_key}, 256'h0);
        check("rst_dec", dec_key, 256'h0);
        rst = 1'b0;

        // FIPS-197 C.3 key
        model_expand(KEY_C3);
        start_key(KEY_C3);
        check("c3_busy", {255'h0, busy}, {255'h0, 1'b1});
        check("c3_kv_low", {255'h0, key_valid}, 256'h0);
        wait_done(cyc);
        check("c3_latency", 256'(cyc), 256'd52);
        check("c3_kv", {255'h0, key_valid}, {255'h0, 1'b1});
        check("c3_busy_off", {255'h0, busy}, 256'h0);
        @(negedge clk);
        check("c3_done_pulse", {255'h0, done}, 256'h0);
        read_rk(4'd0, v);
        check("c3_rk0", {128'h0, v}, {128'h0, 128'h000102030405060708090a0b0c0d0e0f});
        read_rk(4'd1, v);
        check("c3_rk1", {128'h0, v}, {128'h0, 128'h101112131415161718191a1b1c1d1e1f});
        read_rk(4'd2, v);
        check("c3_rk2", {128'h0, v}, {128'h0, 128'ha573c29fa176c498a97fce93a572c09c});
        read_rk(4'd13, v);
        check("c3_rk13", {128'h0, v}, {128'h0, 128'h4e5a6699a9f24fe07e572baacdf8cdea});
        read_rk(4'd14, v);
        check("c3_rk14", {128'h0, v}, {128'h0, 128'h24fc79ccbf0979e9371ac23c6d68de36});
        check("c3_dec", dec_key,
              256'h4e5a6699a9f24fe07e572baacdf8cdea24fc79ccbf0979e9371ac23c6d68de36);
        read_rk(4'd15, v);
        check("c3_idx15", {128'h0, v}, 256'h0);
        sweep("c3_sweep");

        // Restart from key_valid with extra start pulses mid-expansion
        model_expand(KEY_B);
        start_key(KEY_B);
        check("hs_kv_drop", {255'h0, key_valid}, 256'h0);
        done_cnt   = 0;
        first_done = 0;
        for (int c = 1; c <= 60; c++) begin
            start = (c == 5 || c == 30);
            key   = '1;
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (first_done == 0) first_done = c;
            end
        end
        start = 1'b0;
        check("hs_done_cnt", 256'(done_cnt), 256'd1);
        check("hs_done_at", 256'(first_done), 256'd52);
        check("hs_busy_idle", {255'h0, busy}, 256'h0);
        sweep("hs_sweep");

        // Restart with an all-zero key
        model_expand(256'h0);
        start_key(256'h0);
        check("z_kv_drop", {255'h0, key_valid}, 256'h0);
        check("z_busy", {255'h0, busy}, {255'h0, 1'b1});
        wait_done(cyc);
        check("z_latency", 256'(cyc), 256'd52);
        read_rk(4'd0, v);
        check("z_rk0", {128'h0, v}, 256'h0);
        read_rk(4'd1, v);
        check("z_rk1", {128'h0, v}, 256'h0);
        read_rk(4'd2, v);
        check("z_rk2", {128'h0, v}, {128'h0, rk(2)});

        // Reset in the middle of an expansion
        start_key(KEY_C3);
        repeat (19) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("mr_busy", {255'h0, busy}, 256'h0);
        check("mr_done", {255'h0, done}, 256'h0);
        check("mr_kv", {255'h0, key_valid}, 256'h0);
        check("mr_rdkey", {128'h0, rd_key}, 256'h0);
        check("mr_dec", dec_key, 256'h0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("mr_no_done", 256'(done_cnt), 256'd0);
        model_expand(KEY_C3);
        start_key(KEY_C3);
        wait_done(cyc);
        check("mr_latency", 256'(cyc), 256'd52);
        check("mr_dec_after", dec_key,
              256'h4e5a6699a9f24fe07e572baacdf8cdea24fc79ccbf0979e9371ac23c6d68de36);

        // Random keys against the model
        for (int n = 0; n < 200; n++) begin
            rk_key = {$urandom(), $urandom(), $urandom(), $urandom(),
                      $urandom(), $urandom(), $urandom(), $urandom()};
            model_expand(rk_key);
            start_key(rk_key);
            wait_done(cyc);
            check($sformatf("rnd%0d_latency", n), 256'(cyc), 256'd52);
            sweep($sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes256_key_expand.md
# aes256_key_expand

Sequential AES-256 forward key-expansion engine. It accepts a 256-bit cipher key and generates the 60-word schedule at one 32-bit word per clock. It stores the 15 round keys for random read-out by round index. It also presents the final 256 bits (round keys 13 and 14), which is the seed expected by the inverse key schedule on the decryption path.

## Interface
Parameters:
- NK, 8, key length in 32-bit words (fixed for AES-256)
- NR, 14, number of rounds; schedule holds NR+1 = 15 round keys, 4*(NR+1) = 60 words

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request expansion of `key`; sampled only while idle or key_valid
- key  input  256  cipher key; word w0 = key[255:224] … w7 = key[31:0]; sampled on the accepting edge only
- busy  output  1  expansion in progress
- done  output  1  one-cycle pulse when the schedule is complete
- key_valid  output  1  schedule in storage is complete and consistent
- rd_idx  input  4  round-key index 0..14
- rd_key  output  128  registered round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, w[4r] in [127:96]
- dec_key  output  256  {round key 13, round key 14}; meaningful only while key_valid=1

## Operation
- FSM states are IDLE and EXPAND.
- **IDLE + start:**
  - load w0..w7 from key;
  - set word counter i=8;
  - clear key_valid;
  - go to EXPAND.
- **EXPAND:** each cycle writes w[i] = w[i-8] ^ t, where temp = w[i-1] and:
  - i mod 8 = 0: t = SubWord(RotWord(temp)) ^ {Rcon[i/8], 24'h0};
  - i mod 8 = 4: t = SubWord(temp);
  - otherwise: t = temp.
- RotWord is a left rotate by one byte: {b1, b2, b3, b0}.
- Rcon[1..7] = 01, 02, 04, 08, 10, 20, 40 (hex). Rcon is only indexed for i = 8, 16, …, 56.
- **After writing w59:**
  - return to IDLE;
  - pulse done;
  - set key_valid.
- key_valid holds until the next accepted start or reset.
- start while busy is ignored, with no queueing.
- start while key_valid=1 is accepted and restarts the expansion.
- **Read port:**
  - rd_key <= storage[rd_idx] every cycle, independent of state;
  - rd_idx 15 returns 128'h0;
  - reads during EXPAND return the current storage contents, which are undefined to the consumer; consumers must gate on key_valid.
- dec_key is driven combinationally from words w52..w59.
- All arithmetic is GF(2^8) S-box lookup plus XOR. There is no carry and no width growth.

## Timing
- Reset values:
  - busy=0, done=0, key_valid=0, rd_key=0;
  - storage cleared to 0, so dec_key=0;
  - FSM=IDLE, i=0.
- Start is accepted at edge E0: busy=1 after E0, and w0..w7 are readable (rd_idx 0/1) from the E1 read onward.
- Words w8..w59 are written at edges E1..E52, one per edge.
- At E52:
  - busy goes 0;
  - done goes 1 for exactly one cycle (cleared at E53);
  - key_valid goes 1.
- Total latency from accepting edge to done is 52 cycles.
- rd_key latency is 1 cycle after rd_idx is sampled.
- A round key reads correct in the cycle after its last word is written.
- **Restart from key_valid=1:** key_valid drops at E0, with the same 52-cycle sequence.
- **Reset mid-expansion:** asynchronous clear of all state. No done pulse. Storage is zeroed, and the next start begins fresh.
- **start coincident with the E52 completion edge:** not accepted, because busy=1. Issue it one cycle later.

## Structure
- **Shared package aes_pkg:**
  - NK, NR and NW=60 constants;
  - Rcon table;
  - FSM state enum;
  - RotWord function.
- **Sub-module aes_sbox:** combinational 8-bit forward S-box. Four instances form SubWord, and they are reused by the cipher datapath.
- **Storage:** 60x32 register array (or 15x128 with word write-enable).

## Test plan
- **FIPS-197 C.3 vector:**
  - stimulus: key=000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, start pulse;
  - done exactly 52 cycles after the accepting edge;
  - rd_idx 0 -> 000102030405060708090a0b0c0d0e0f;
  - rd_idx 1 -> 101112131415161718191a1b1c1d1e1f;
  - rd_idx 2 -> a573c29fa176c498a97fce93a572c09c.
- **Same run, final keys:**
  - rd_idx 13 -> 4e5a6699a9f24fe07e572baacdf8cdea;
  - rd_idx 14 -> 24fc79ccbf0979e9371ac23c6d68de36;
  - dec_key = 4e5a6699a9f24fe07e572baacdf8cdea24fc79ccbf0979e9371ac23c6d68de36.
- **Handshake:**
  - start re-pulsed at cycles 5 and 30 of an expansion -> ignored, single done, results unchanged;
  - start while key_valid=1 with key=0 -> key_valid drops next cycle;
  - after 52 cycles, rd_idx 0 -> 0, rd_idx 1 -> 0.
- **Reset mid-operation:** assert rst at cycle 20 of expansion -> busy/done/key_valid/rd_key=0 immediately, no done pulse; a fresh start then completes normally.
- **Boundary reads:** rd_idx=15 -> 0. Sweeping rd_idx 0..14 back-to-back returns each key one cycle later against a model of the FIPS-197 schedule.
- **Random regression:** 200 random keys -> all 15 round keys match a reference model, and dec_key matches {rk13, rk14}.
